// File: rtl/conv_window_fetch.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_fetch
// Description : Read-only requester for one port of the shared memory
//               arbiter. On start, fetches a KxK pixel window from a
//               row-major image (one word per request, row-major order) and
//               presents it as a registered parallel vector to the MAC/PE
//               stage.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               start            - begin a fetch (honoured only when idle)
//               base_addr        - address of window element (0,0)
//               row_stride       - address distance between window rows
//               busy / done      - fetch in progress / one-cycle completion
//               window_valid     - window contents complete (sticky)
//               window_data      - element (r,c) at [(r*K+c)*DW +: DW]
//               mem_w, mem_sel, mem_ready, mem_addr, mem_rdata
//                                - arbiter port handshake and buses
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_fetch #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATABUS_WIDTH = 32,
    parameter int K             = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [ADDR_WIDTH-1:0]           row_stride,
    output logic                            busy,
    output logic                            done,
    output logic                            window_valid,
    output logic [K*K*DATABUS_WIDTH-1:0]    window_data,
    output logic                            mem_w,
    output logic                            mem_sel,
    input  logic                            mem_ready,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic [DATABUS_WIDTH-1:0]        mem_rdata
);

    localparam int NUM_ELEM = K * K;
    localparam int IDX_W    = (K > 1) ? $clog2(K) : 1;
    localparam int ELEM_W   = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

    localparam logic [IDX_W-1:0]  c_LAST_COL  = IDX_W'(K - 1);
    localparam logic [ELEM_W-1:0] c_LAST_ELEM = ELEM_W'(NUM_ELEM - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]                     r_state;
    logic [IDX_W-1:0]               r_row;
    logic [IDX_W-1:0]               r_col;
    logic [ELEM_W-1:0]              r_elem;      // r*K+c, tracked alongside r/c
    logic [ADDR_WIDTH-1:0]          r_stride;
    logic [ADDR_WIDTH-1:0]          r_row_base;  // base + r*stride
    logic [ADDR_WIDTH-1:0]          r_addr;      // row_base + c
    logic                           r_sel;
    logic                           r_busy;
    logic                           r_done;
    logic                           r_valid;
    logic [K*K*DATABUS_WIDTH-1:0]   r_window;

    // Outputs are all taken straight from registers; the next-state values of
    // sel/busy/done are computed alongside each state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_elem     <= '0;
            r_stride   <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
            r_sel      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_window   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_stride   <= row_stride;
                        r_row_base <= base_addr;
                        r_addr     <= base_addr;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_elem     <= '0;
                        r_valid    <= 1'b0;
                        r_sel      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        r_window[32'(r_elem) * DATABUS_WIDTH +: DATABUS_WIDTH] <= mem_rdata;
                        r_sel   <= 1'b0;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Waiting for ready to fall keeps a single long ready
                    // level from being taken as a second grant.
                    if (!mem_ready) begin
                        if (r_elem == c_LAST_ELEM) begin
                            r_valid <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_elem  <= r_elem + 1'b1;
                            r_sel   <= 1'b1;
                            r_state <= S_REQ;
                            if (r_col == c_LAST_COL) begin
                                r_col      <= '0;
                                r_row      <= r_row + 1'b1;
                                r_row_base <= r_row_base + r_stride;
                                r_addr     <= r_row_base + r_stride;
                            end else begin
                                r_col  <= r_col + 1'b1;
                                r_addr <= r_addr + 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_sel   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign window_valid = r_valid;
    assign window_data  = r_window;
    assign mem_w        = 1'b0;
    assign mem_sel      = r_sel;
    assign mem_addr     = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_fetch
// Description : Self-checking bench for conv_window_fetch with an arbiter
//               port model (ready follows sel by one register, optional
//               stalls and a stuck-high ready) and a window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_fetch;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int K  = 3;
    localparam int NE = K * K;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [AW-1:0]      base_addr;
    logic [AW-1:0]      row_stride;
    logic               busy;
    logic               done;
    logic               window_valid;
    logic [NE*DW-1:0]   window_data;
    logic               mem_w;
    logic               mem_sel;
    logic               mem_ready = 1'b0;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_rdata;

    int checks   = 0;
    int failures = 0;

    // port model controls
    logic [DW-1:0]      salt      = '0;
    logic               hold_high = 1'b0;
    logic [AW-1:0]      stall_addr = '0;
    int                 stall_len  = 0;
    int                 stall_cnt  = 0;

    // monitors
    logic [AW-1:0]      grants[$];
    int                 stab_err  = 0;
    logic               hold_chk  = 1'b0;
    logic [AW-1:0]      held_addr = '0;

    conv_window_fetch #(.ADDR_WIDTH(AW), .DATABUS_WIDTH(DW), .K(K)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .row_stride(row_stride), .busy(busy), .done(done),
        .window_valid(window_valid), .window_data(window_data),
        .mem_w(mem_w), .mem_sel(mem_sel), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (32'(a) + 32'h1000) ^ salt;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    // reference: element e of a window at base b with stride s
    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] b, input logic [AW-1:0] s, input int e);
        return AW'(int'(b) + (e / K) * int'(s) + (e % K));
    endfunction

    always @(posedge clk) begin
        if (hold_high)
            mem_ready <= 1'b1;
        else if (mem_sel && mem_addr == stall_addr && stall_cnt < stall_len) begin
            mem_ready <= 1'b0;
            stall_cnt <= stall_cnt + 1;
        end else
            mem_ready <= mem_sel;
        if (!mem_sel) stall_cnt <= 0;
        if (!rst && mem_sel && mem_ready) grants.push_back(mem_addr);
        // a request not granted at this edge must still be presented, unchanged
        if (hold_chk && !(mem_sel && mem_addr == held_addr)) stab_err <= stab_err + 1;
        hold_chk  <= mem_sel && !mem_ready && !rst;
        held_addr <= mem_addr;
    end

    // Pulses start for edge E0 and counts edges until done is seen.
    task automatic do_fetch(input logic [AW-1:0] b, input logic [AW-1:0] s, input int restart_at,
                            output int done_edge, output logic valid_e0, output logic done_next);
        grants.delete();
        @(negedge clk);
        base_addr = b; row_stride = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; valid_e0 = window_valid;
        done_edge = -1; done_next = 1'b0;
        for (int n = 1; n <= 600; n++) begin
            if (n == restart_at) begin start = 1'b1; base_addr = ~b; end
            else start = 1'b0;
            @(negedge clk);
            if (done) begin
                done_edge = n;
                start = 1'b0;
                @(negedge clk);
                done_next = done;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; base_addr = '0; row_stride = '0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, mem_sel, window_valid} !== 4'b0) begin failures++;
            $display("FAIL reset_flags got busy/done/sel/valid=%b want 0000", {busy, done, mem_sel, window_valid}); end
        checks++; if (mem_addr !== '0 || window_data !== '0) begin failures++;
            $display("FAIL reset_data got addr=%h data!=0 want 0", mem_addr); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || mem_w !== 1'b0) begin failures++;
            $display("FAIL idle_after_reset got busy=%b mem_w=%b want 0 0", busy, mem_w); end
    endtask

    task automatic test_basic;
        int de; logic v0, dn; int se;
        salt = '0; se = stab_err;
        do_fetch(16'h0100, 16'h0040, -1, de, v0, dn);
        checks++; if (grants.size() != NE) begin failures++;
            $display("FAIL basic_grant_count got %0d want %0d", grants.size(), NE); end
        for (int e = 0; e < NE && e < grants.size(); e++) begin
            checks++; if (grants[e] !== exp_addr(16'h0100, 16'h0040, e)) begin failures++;
                $display("FAIL basic_addr[%0d] got %h want %h", e, grants[e], exp_addr(16'h0100, 16'h0040, e)); end
        end
        checks++; if (de != 36 || dn !== 1'b0) begin failures++;
            $display("FAIL basic_done got edge=%0d next=%b want 36 0", de, dn); end
        checks++; if (window_valid !== 1'b1) begin failures++;
            $display("FAIL basic_valid got %b want 1", window_valid); end
        checks++; if (window_data[4*DW +: DW] !== 32'h1141 || window_data[8*DW +: DW] !== 32'h1182) begin failures++;
            $display("FAIL basic_elems got e4=%h e8=%h want 1141 1182", window_data[4*DW +: DW], window_data[8*DW +: DW]); end
        checks++; if (stab_err != se || busy !== 1'b0) begin failures++;
            $display("FAIL basic_stable got stab_err=%0d busy=%b want %0d 0", stab_err, busy, se); end
    endtask

    task automatic test_stall;
        int de; logic v0, dn; int se;
        se = stab_err; stall_addr = 16'h0102; stall_len = 10;
        do_fetch(16'h0100, 16'h0040, -1, de, v0, dn);
        stall_len = 0;
        checks++; if (de != 46) begin failures++;
            $display("FAIL stall_done_edge got %0d want 46", de); end
        checks++; if (stab_err != se) begin failures++;
            $display("FAIL stall_req_stable got %0d errors want 0", stab_err - se); end
        for (int e = 0; e < NE; e++) begin
            checks++; if (window_data[e*DW +: DW] !== mem_word(exp_addr(16'h0100, 16'h0040, e))) begin failures++;
                $display("FAIL stall_elem[%0d] got %h want %h", e, window_data[e*DW +: DW], mem_word(exp_addr(16'h0100, 16'h0040, e))); end
        end
    endtask

    task automatic test_wrap;
        int de; logic v0, dn;
        logic [AW-1:0] want[NE] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h000E, 16'h000F,
                                    16'h0010, 16'h001E, 16'h001F, 16'h0020};
        do_fetch(16'hFFFE, 16'h0010, -1, de, v0, dn);
        checks++; if (grants.size() != NE) begin failures++;
            $display("FAIL wrap_grant_count got %0d want %0d", grants.size(), NE); end
        for (int e = 0; e < NE && e < grants.size(); e++) begin
            checks++; if (grants[e] !== want[e]) begin failures++;
                $display("FAIL wrap_addr[%0d] got %h want %h", e, grants[e], want[e]); end
        end
    endtask

    task automatic test_restart;
        int de; logic v0, dn;
        do_fetch(16'h0200, 16'h0020, 10, de, v0, dn);
        checks++; if (de != 36 || grants.size() != NE) begin failures++;
            $display("FAIL restart_ignored got edge=%0d grants=%0d want 36 %0d", de, grants.size(), NE); end
        for (int e = 0; e < NE && e < grants.size(); e++) begin
            checks++; if (grants[e] !== exp_addr(16'h0200, 16'h0020, e)) begin failures++;
                $display("FAIL restart_addr[%0d] got %h want %h", e, grants[e], exp_addr(16'h0200, 16'h0020, e)); end
        end
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL restart_no_queue got busy=%b want 0", busy); end
        do_fetch(16'h0300, 16'h0008, -1, de, v0, dn);
        checks++; if (v0 !== 1'b0) begin failures++;
            $display("FAIL restart_valid_drop got %b want 0", v0); end
        checks++; if (de != 36 || grants.size() != NE || grants[0] !== 16'h0300) begin failures++;
            $display("FAIL restart_fresh got edge=%0d grants=%0d want 36 %0d", de, grants.size(), NE); end
    endtask

    task automatic test_reset_mid;
        int de; logic v0, dn; bit hit;
        logic [AW-1:0] a5;
        a5 = exp_addr(16'h0400, 16'h0100, 5);
        @(negedge clk);
        base_addr = 16'h0400; row_stride = 16'h0100; start = 1'b1;
        @(negedge clk);
        start = 1'b0; hit = 0;
        for (int n = 0; n < 200; n++) begin
            if (mem_sel && mem_addr == a5) begin hit = 1; break; end
            @(negedge clk);
        end
        checks++; if (!hit) begin failures++;
            $display("FAIL rstmid_reach got no request at %h want request", a5); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({mem_sel, busy, window_valid, done} !== 4'b0 || window_data !== '0 || mem_addr !== '0) begin failures++;
            $display("FAIL rstmid_state got sel/busy/valid/done=%b addr=%h want 0000 0", {mem_sel, busy, window_valid, done}, mem_addr); end
        repeat (3) @(negedge clk);
        do_fetch(16'h0400, 16'h0100, -1, de, v0, dn);
        checks++; if (de != 36 || grants.size() != NE) begin failures++;
            $display("FAIL rstmid_refetch got edge=%0d grants=%0d want 36 %0d", de, grants.size(), NE); end
        for (int e = 0; e < NE && e < grants.size(); e++) begin
            checks++; if (grants[e] !== exp_addr(16'h0400, 16'h0100, e)) begin failures++;
                $display("FAIL rstmid_addr[%0d] got %h want %h", e, grants[e], exp_addr(16'h0400, 16'h0100, e)); end
        end
    endtask

    task automatic test_hold_ready;
        int de; logic v0, dn; bit seen;
        logic [DW-1:0] old1;
        salt = 32'h0000_A5A5;
        do_fetch(16'h0500, 16'h0010, -1, de, v0, dn);
        old1 = window_data[1*DW +: DW];
        salt = 32'h5A5A_0000;
        hold_high = 1'b1;
        grants.delete();
        @(negedge clk);
        base_addr = 16'h0500; row_stride = 16'h0010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b1 || mem_sel !== 1'b0 || done !== 1'b0 || grants.size() != 1) begin failures++;
            $display("FAIL hold_stuck got busy=%b sel=%b done=%b grants=%0d want 1 0 0 1", busy, mem_sel, done, grants.size()); end
        checks++; if (window_data[0*DW +: DW] !== mem_word(16'h0500) || window_data[1*DW +: DW] !== old1) begin failures++;
            $display("FAIL hold_elems got e0=%h e1=%h want %h %h", window_data[0*DW +: DW], window_data[1*DW +: DW], mem_word(16'h0500), old1); end
        hold_high = 1'b0;
        seen = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        checks++; if (!seen || grants.size() != NE) begin failures++;
            $display("FAIL hold_resume got done=%0d grants=%0d want 1 %0d", seen, grants.size(), NE); end
        for (int e = 0; e < NE; e++) begin
            checks++; if (window_data[e*DW +: DW] !== mem_word(exp_addr(16'h0500, 16'h0010, e))) begin failures++;
                $display("FAIL hold_elem[%0d] got %h want %h", e, window_data[e*DW +: DW], mem_word(exp_addr(16'h0500, 16'h0010, e))); end
        end
    endtask

    task automatic test_random;
        int de; logic v0, dn; int extra; int se;
        logic [AW-1:0] b, s;
        for (int it = 0; it < 6; it++) begin
            b = AW'($urandom); s = AW'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            salt = $urandom;
            stall_addr = exp_addr(b, s, $urandom_range(0, NE - 1));
            stall_len = $urandom_range(0, 5);
            extra = 0;
            for (int e = 0; e < NE; e++) if (exp_addr(b, s, e) == stall_addr) extra += stall_len;
            se = stab_err;
            do_fetch(b, s, -1, de, v0, dn);
            stall_len = 0;
            checks++; if (de != 36 + extra || dn !== 1'b0 || window_valid !== 1'b1 || stab_err != se) begin failures++;
                $display("FAIL rand%0d_timing got edge=%0d valid=%b want %0d 1", it, de, window_valid, 36 + extra); end
            checks++; if (grants.size() != NE) begin failures++;
                $display("FAIL rand%0d_count got %0d want %0d", it, grants.size(), NE); end
            for (int e = 0; e < NE; e++) begin
                checks++; if (window_data[e*DW +: DW] !== mem_word(exp_addr(b, s, e))) begin failures++;
                    $display("FAIL rand%0d_elem[%0d] got %h want %h", it, e, window_data[e*DW +: DW], mem_word(exp_addr(b, s, e))); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_wrap;
        test_restart;
        test_reset_mid;
        test_hold_ready;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_window_fetch.md
Name: conv_window_fetch

Overview:
- Upstream requester for one port of the shared memory arbiter.
- On `start`, reads a KxK pixel window (default 3x3) from a row-major image, one word per request, and presents the full window as a registered parallel vector to the downstream MAC/PE stage.
- One instance drives one arbiter port: `mem_w_ind[n]`, `mem_sel_ind[n]`, `mem_ready_ind[n]`, `addr_bus_ind[n]`, and the read side of `data_bus_ind[n]`.

Parameters:
- ADDR_WIDTH, 16, address width; matches the arbiter.
- DATABUS_WIDTH, 32, data word width; matches the arbiter.
- K, 3, window side; window holds K*K words, K >= 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin fetch; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  address of window element (0,0); sampled with start.
- row_stride  in  ADDR_WIDTH  address distance between window rows; sampled with start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the window is complete.
- window_valid  out  1  window contents valid; sticky until the next accepted start or rst.
- window_data  out  K*K*DATABUS_WIDTH  element (r,c) at bits [(r*K+c)*DATABUS_WIDTH +: DATABUS_WIDTH].
- mem_w  out  1  constant 0 (read-only requester).
- mem_sel  out  1  request to arbiter port.
- mem_ready  in  1  arbiter port ready.
- mem_addr  out  ADDR_WIDTH  request address.
- mem_rdata  in  DATABUS_WIDTH  read data from the port data bus; valid while mem_ready=1.

Behaviour:
- Reset (rst=1 at posedge), from any state including mid-fetch:
  - state=IDLE, r=c=0.
  - mem_sel=0, mem_addr=0, busy=0, done=0.
  - window_valid=0, window_data=0.
  - A request in flight is dropped; mem_sel falls on the reset edge.
- States: IDLE, REQ, RELEASE, DONE.
  - mem_sel = (state==REQ).
  - busy = (state!=IDLE).
  - done = (state==DONE).
  - All outputs are register-driven; no combinational path from inputs to outputs.
- IDLE:
  - start=1 latches base_addr and row_stride, sets r=c=0, loads mem_addr=base_addr, clears window_valid, then goes to REQ.
  - start=0: stay.
- REQ:
  - mem_sel held 1 and mem_addr held stable until mem_ready=1.
  - On the edge with mem_ready=1: capture mem_rdata into element (r,c), go to RELEASE.
  - No timeout; the block waits indefinitely.
- RELEASE:
  - mem_sel=0; wait until mem_ready=0. This ensures one ready level is never counted as two grants.
  - On the edge with mem_ready=0:
    - If r==K-1 and c==K-1, go to DONE and set window_valid=1 on the same edge.
    - Otherwise advance: c+1; or, when c==K-1, c=0 and r+1. Load mem_addr and go to REQ.
- DONE: one cycle, then IDLE unconditionally.
- start while busy (REQ/RELEASE/DONE) is ignored, with no queuing.
- Address arithmetic: mem_addr = base + r*row_stride + c, computed modulo 2^ADDR_WIDTH.
  - Wraps silently past the top of memory.
  - Implemented incrementally with a row-base register (no multiplier): row_base += row_stride when the row advances.
- Fetch order is row-major: (0,0),(0,1),...,(K-1,K-1).
- window_data is updated element-by-element during the fetch; consumers use it only when window_valid=1.
- Minimum cost is 4 cycles per element when ready follows sel with a one-cycle register delay: REQ, REQ, RELEASE, RELEASE.

Test Plan:
- Memory model mem[a]=a+0x1000, ready<=sel each cycle; K=3, base=0x0100, stride=0x0040, start pulse at edge E0:
  - Addresses in order: 0x100,101,102,140,141,142,180,181,182.
  - done high for exactly the one cycle after E36, window_valid=1 from E36.
  - Element 4 = 0x1141, element 8 = 0x1182.
- Ready stalled 10 cycles on element 2 -> mem_sel and mem_addr=0x102 stay stable throughout; done slips by exactly 10 cycles; all values correct.
- base=0xFFFE, stride=0x0010 -> addresses FFFE,FFFF,0000,000E,000F,0010,001E,001F,0020 (mod 2^16 wrap).
- Second start during fetch (at E10) -> ignored; address sequence unchanged; a new start after done -> window_valid drops the next cycle and a fresh fetch runs.
- rst asserted in REQ of element 5 -> next cycle mem_sel=0, busy=0, window_valid=0, window_data=0; a subsequent start refetches from element 0.
- mem_ready held high across two elements (model never drops it) -> block stays in RELEASE after the first capture, with only one element captured; releasing ready resumes the fetch.
